axi_soc_sram_bridge: RTL and testbench
======================================

Name: axi_soc_sram_bridge

Overview:
- Struct-port AXI4 slave. Consumes the `ariane_axi_soc::req_t` / `resp_t` pair produced by the AXI_BUS-to-struct adapter on a SoC slave port.
- Drives a single-port, 1-cycle-latency SRAM macro.
- Serialises read and write bursts (FIXED/INCR/WRAP), one transaction at a time.
- Used for on-chip scratchpad/boot RAM behind the SoC crossbar.

Parameters:
- NumWords, 1024, SRAM depth in data words; power of two, ≥2.
- DataWidth, 64, must equal the `ariane_axi_soc` data width; byte enables = DataWidth/8.
- AddrWidth, 64, must equal the `ariane_axi_soc` address width.
- ArbWriteFirst, 1, priority after reset when AW and AR are valid in the same cycle.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- axi_req_i  in  ariane_axi_soc::req_t  AW/W/AR channels, b_ready, r_ready
- axi_resp_o  out  ariane_axi_soc::resp_t  readies, B channel, R channel
- mem_req_o  out  1  SRAM access strobe
- mem_we_o  out  1  1=write, 0=read
- mem_addr_o  out  $clog2(NumWords)  word index
- mem_wdata_o  out  DataWidth  write data
- mem_be_o  out  DataWidth/8  byte enables
- mem_rdata_i  in  DataWidth  read data, valid the cycle after a read mem_req_o

Behaviour:
- One clock: clk_i. Reset: rst_ni, asynchronous, active-low.
- Reset values:
  - All resp valids/readies = 0; b/r payload = 0.
  - mem_* outputs = 0.
  - FSM = IDLE; priority = ArbWriteFirst.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_REQ, RD_DATA.
- IDLE:
  - aw_ready and ar_ready are combinational, asserted only for the selected channel.
  - If both aw_valid and ar_valid are high, the priority bit selects; the bit toggles after every grant to the contended winner (round-robin).
  - Grant latches id, addr, len, size, burst, and beat count = 0.
  - Next state: WR_DATA (write) or RD_REQ (read).
- WR_DATA:
  - w_ready = 1.
  - Each W handshake drives, the same cycle: mem_req_o=1, mem_we_o=1, mem_be_o=w.strb, mem_wdata_o=w.data.
  - Address advances after each beat.
  - w.last ends the burst regardless of len; go to WR_RESP.
- WR_RESP:
  - b_valid=1, b.id = latched id, b.resp = OKAY (2'b00).
  - Payload is held stable until b_ready; then go to IDLE.
- RD_REQ:
  - mem_req_o=1, mem_we_o=0 for one cycle; go to RD_DATA.
- RD_DATA:
  - mem_rdata_i is captured into an R register on entry.
  - r_valid=1 with r.id, r.data, r.resp=OKAY, r.last = (beat==len).
  - The register is held until r_ready.
  - On handshake: if last, go to IDLE; otherwise advance the address and go to RD_REQ.
  - Throughput: 1 beat per 2 cycles minimum.
- Address arithmetic, with step = 1<<size:
  - FIXED: address unchanged.
  - INCR: address + step, full AddrWidth with natural wrap.
  - WRAP: boundary = (len+1)*step; new address = (addr & ~(boundary-1)) | ((addr+step) & (boundary-1)). len ∈ {1,3,7,15} is guaranteed by the protocol.
  - Burst encoding 2'b11 is treated as INCR.
- Word index = (addr >> log2(DataWidth/8)) mod NumWords. Unaligned start addresses are honoured only through strobes.
- aw.atop is guaranteed 0 by the upstream atomics filter and is ignored.
- Unrelated readies stay low in each state: no AW/AR acceptance outside IDLE, and no w_ready outside WR_DATA.
- Reset mid-burst: immediate return to IDLE; any outstanding B or R beats are dropped. The system resets both sides together.

Optional Feature:
- Macro: AXI_SOC_SRAM_BRIDGE_RANGE_ERR_EN.
- Defined:
  - A transaction is out of range if its starting word index is ≥ NumWords, or the address bits above log2(NumWords*DataWidth/8) are non-zero.
  - Out-of-range writes: W beats are accepted with mem_req_o=0, and B returns SLVERR (2'b10).
  - Out-of-range reads: the bridge skips RD_REQ and returns len+1 beats with r.data=0, resp=SLVERR, r.last on the final beat.
- Undefined: addresses alias modulo NumWords, and all responses are OKAY.

Test Plan:
- Write then read, 8-byte aligned: single write to addr 0x10, data 0xDEADBEEF_CAFEF00D, strb 0xFF, id 3. Expect mem_addr_o=2 and B id 3 OKAY. Single read of 0x10 returns the same data, r.last=1.
- INCR burst with backpressure: write addr 0x0, len 3, size 3, data k+1 for beats 0-3, then read back with r_ready toggled 1/0 every cycle. Expect 4 beats 1,2,3,4, r.last only on beat 3, data held while r_ready=0.
- WRAP burst: write words 0-3 with 0xA0-0xA3, then read addr 0x18, len 3, size 3, WRAP. Expect beat order 0xA3,0xA0,0xA1,0xA2.
- Strobe and FIXED: FIXED write to addr 0x8, len 1, beat0 0x1111…, strb 0xFF; beat1 0x2222…, strb 0x0F. Readback = 0x11111111_22222222.
- Contention: AW and AR valid in the same cycle, twice in a row, ArbWriteFirst=1. Expect write granted first, read second, the next contention goes to the write again. B handshake while b_ready=0 is held for 5 cycles.
- With AXI_SOC_SRAM_BRIDGE_RANGE_ERR_EN, NumWords=1024: read at 0x2000, len 1. Expect 2 beats, data 0, resp SLVERR, and no mem_req_o. A write at 0x2000 gives B SLVERR and no mem write.

Source files
------------

// File: rtl/axi_soc_sram_bridge.sv
// axi_soc_sram_bridge: AXI4 slave to single-port SRAM bridge; define AXI_SOC_SRAM_BRIDGE_RANGE_ERR_EN for SLVERR on out-of-range accesses
package ariane_axi_soc;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned IdWidth = 4;
  localparam int unsigned UserWidth = 1;
  localparam int unsigned StrbWidth = DataWidth / 8;
  typedef logic [IdWidth-1:0] id_t;
  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbWidth-1:0] strb_t;
  typedef logic [UserWidth-1:0] user_t;
  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    user_t       user;
  } aw_chan_t;
  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;
  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;
  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    user_t      user;
  } ar_chan_t;
  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;
  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;
  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

module axi_soc_sram_bridge #(
  parameter int unsigned NumWords      = 1024,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned AddrWidth     = 64,
  parameter bit          ArbWriteFirst = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  ariane_axi_soc::req_t        axi_req_i,
  output ariane_axi_soc::resp_t       axi_resp_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [$clog2(NumWords)-1:0] mem_addr_o,
  output logic [DataWidth-1:0]        mem_wdata_o,
  output logic [DataWidth/8-1:0]      mem_be_o,
  input  logic [DataWidth-1:0]        mem_rdata_i
);
  localparam int unsigned MemAw    = $clog2(NumWords);
  localparam int unsigned ByteBits = $clog2(DataWidth / 8);

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_REQ, RD_DATA} state_t;

  state_t                r_state, w_next;
  logic                  r_prio;
  ariane_axi_soc::id_t   r_id;
  logic [AddrWidth-1:0]  r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;
  logic                  r_hold;
  logic [DataWidth-1:0]  r_rdata;
  logic                  w_sel_w, w_aw_hs, w_ar_hs, w_w_hs, w_r_hs, w_last, w_start_err;
  logic [AddrWidth-1:0]  w_next_addr;
  logic                  w_unused;

  // Next beat address for FIXED / INCR / WRAP; the reserved encoding behaves as INCR
  function automatic logic [AddrWidth-1:0] f_next(input logic [AddrWidth-1:0] a, input logic [2:0] sz,
                                                  input logic [7:0] len, input logic [1:0] bt);
    logic [AddrWidth-1:0] step, mask;
    step = AddrWidth'(1) << sz;
    mask = ((AddrWidth'(len) + AddrWidth'(1)) << sz) - AddrWidth'(1);
    return bt == 2'b00 ? a : bt == 2'b10 ? ((a & ~mask) | ((a + step) & mask)) : a + step;
  endfunction

  assign w_unused    = ^axi_req_i;
  assign w_sel_w     = axi_req_i.aw_valid && (!axi_req_i.ar_valid || r_prio);
  assign w_aw_hs     = r_state == IDLE && w_sel_w;
  assign w_ar_hs     = r_state == IDLE && axi_req_i.ar_valid && !w_sel_w;
  assign w_w_hs      = r_state == WR_DATA && axi_req_i.w_valid;
  assign w_r_hs      = r_state == RD_DATA && axi_req_i.r_ready;
  assign w_last      = r_beat == r_len;
  assign w_next_addr = f_next(r_addr, r_size, r_len, r_burst);

`ifdef AXI_SOC_SRAM_BRIDGE_RANGE_ERR_EN
  localparam int unsigned RangeBits = MemAw + ByteBits;
  logic [AddrWidth-1:0] w_start_addr;
  assign w_start_addr = w_sel_w ? axi_req_i.aw.addr : axi_req_i.ar.addr;
  assign w_start_err  = |(w_start_addr >> RangeBits);
`else
  assign w_start_err = 1'b0;
`endif

  // State register, transaction context, arbitration priority and read-data capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_prio  <= ArbWriteFirst;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
      r_hold  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_aw_hs || w_ar_hs) begin
        r_id    <= w_aw_hs ? axi_req_i.aw.id : axi_req_i.ar.id;
        r_addr  <= w_aw_hs ? axi_req_i.aw.addr : axi_req_i.ar.addr;
        r_len   <= w_aw_hs ? axi_req_i.aw.len : axi_req_i.ar.len;
        r_size  <= w_aw_hs ? axi_req_i.aw.size : axi_req_i.ar.size;
        r_burst <= w_aw_hs ? axi_req_i.aw.burst : axi_req_i.ar.burst;
        r_beat  <= '0;
        r_err   <= w_start_err;
      end
      if (r_state == IDLE && axi_req_i.aw_valid && axi_req_i.ar_valid) r_prio <= !r_prio;
      if (w_w_hs || w_r_hs) begin
        r_addr <= w_next_addr;
        r_beat <= r_beat + 8'd1;
      end
      r_hold <= r_state == RD_DATA && !w_r_hs;
      if (r_state == RD_DATA && !r_hold) r_rdata <= mem_rdata_i;
    end
  end

  // Next-state logic, AXI handshakes/responses and SRAM strobes
  always_comb begin
    axi_resp_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    w_next      = r_state;
    case (r_state)
      IDLE: begin
        axi_resp_o.aw_ready = w_sel_w;
        axi_resp_o.ar_ready = axi_req_i.ar_valid && !w_sel_w;
        w_next = w_aw_hs ? WR_DATA : w_ar_hs ? (w_start_err ? RD_DATA : RD_REQ) : IDLE;
      end
      WR_DATA: begin
        axi_resp_o.w_ready = 1'b1;
        if (axi_req_i.w_valid) begin
          mem_req_o   = !r_err;
          mem_we_o    = !r_err;
          mem_addr_o  = r_addr[ByteBits +: MemAw];
          mem_wdata_o = axi_req_i.w.data;
          mem_be_o    = axi_req_i.w.strb;
          w_next      = axi_req_i.w.last ? WR_RESP : WR_DATA;
        end
      end
      WR_RESP: begin
        axi_resp_o.b_valid = 1'b1;
        axi_resp_o.b.id    = r_id;
        axi_resp_o.b.resp  = r_err ? 2'b10 : 2'b00;
        w_next = axi_req_i.b_ready ? IDLE : WR_RESP;
      end
      RD_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = r_addr[ByteBits +: MemAw];
        w_next     = RD_DATA;
      end
      RD_DATA: begin
        axi_resp_o.r_valid = 1'b1;
        axi_resp_o.r.id    = r_id;
        axi_resp_o.r.data  = r_err ? '0 : r_hold ? r_rdata : mem_rdata_i;
        axi_resp_o.r.resp  = r_err ? 2'b10 : 2'b00;
        axi_resp_o.r.last  = w_last;
        w_next = !axi_req_i.r_ready ? RD_DATA : w_last ? IDLE : r_err ? RD_DATA : RD_REQ;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_soc_sram_bridge.sv
// tb_axi_soc_sram_bridge: directed self-checking bench for axi_soc_sram_bridge with a behavioural SRAM
module tb_axi_soc_sram_bridge;
  logic clk, rst_n;
  ariane_axi_soc::req_t  req;
  ariane_axi_soc::resp_t resp;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_be;
  logic [63:0] mem [1024];
  int n_asserts = 0;
  int n_fail = 0;
  int n_memreq = 0;

  axi_soc_sram_bridge #(.NumWords(1024), .DataWidth(64), .AddrWidth(64), .ArbWriteFirst(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .axi_req_i(req), .axi_resp_o(resp),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle-latency byte-enabled SRAM and a count of every access strobe
  always @(posedge clk) begin
    if (mem_req) begin
      n_memreq <= n_memreq + 1;
      if (mem_we) begin
        for (int i = 0; i < 8; i++) if (mem_be[i]) mem[mem_addr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [63:0] a, input logic [7:0] l, input logic [1:0] bt, input logic [3:0] id);
    int t = 0;
    req.aw.addr = a; req.aw.len = l; req.aw.size = 3'd3; req.aw.burst = bt; req.aw.id = id;
    req.aw_valid = 1'b1;
    @(negedge clk);
    while (!resp.aw_ready && t < 20) begin @(negedge clk); t++; end
    chk("aw_ready", resp.aw_ready, 1'b1);
    @(posedge clk); #1 req.aw_valid = 1'b0;
  endtask

  task automatic ar_send(input logic [63:0] a, input logic [7:0] l, input logic [1:0] bt, input logic [3:0] id);
    int t = 0;
    req.ar.addr = a; req.ar.len = l; req.ar.size = 3'd3; req.ar.burst = bt; req.ar.id = id;
    req.ar_valid = 1'b1;
    @(negedge clk);
    while (!resp.ar_ready && t < 20) begin @(negedge clk); t++; end
    chk("ar_ready", resp.ar_ready, 1'b1);
    @(posedge clk); #1 req.ar_valid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] s, input logic l, input logic exp_req, input logic [9:0] exp_addr);
    int t = 0;
    req.w.data = d; req.w.strb = s; req.w.last = l; req.w_valid = 1'b1;
    @(negedge clk);
    while (!resp.w_ready && t < 20) begin @(negedge clk); t++; end
    chk("w_ready", resp.w_ready, 1'b1);
    chk("w_mem_req", mem_req, exp_req);
    if (exp_req) begin
      chk("w_mem_we", mem_we, 1'b1);
      chk("w_mem_addr", mem_addr, exp_addr);
      chk("w_mem_wdata", mem_wdata, d);
      chk("w_mem_be", mem_be, s);
    end
    @(posedge clk); #1 req.w_valid = 1'b0;
  endtask

  task automatic b_recv(input logic [3:0] id, input logic [1:0] rs, input int hold);
    int t = 0;
    req.b_ready = 1'b0;
    @(negedge clk);
    while (!resp.b_valid && t < 20) begin @(negedge clk); t++; end
    for (int i = 0; i < hold; i++) begin
      chk("b_hold_valid", resp.b_valid, 1'b1);
      chk("b_hold_id", resp.b.id, id);
      chk("b_hold_readies", {resp.aw_ready, resp.ar_ready, resp.w_ready}, 3'b000);
      @(negedge clk);
    end
    chk("b_valid", resp.b_valid, 1'b1);
    chk("b_id", resp.b.id, id);
    chk("b_resp", resp.b.resp, rs);
    req.b_ready = 1'b1;
    @(posedge clk); #1 req.b_ready = 1'b0;
  endtask

  task automatic r_recv(input logic [63:0] d, input logic l, input logic [1:0] rs, input logic [3:0] id);
    int t = 0;
    req.r_ready = 1'b1;
    @(negedge clk);
    while (!resp.r_valid && t < 20) begin @(negedge clk); t++; end
    chk("r_valid", resp.r_valid, 1'b1);
    chk("r_data", resp.r.data, d);
    chk("r_last", resp.r.last, l);
    chk("r_resp", resp.r.resp, rs);
    chk("r_id", resp.r.id, id);
    @(posedge clk); #1 req.r_ready = 1'b0;
  endtask

  initial begin
    int k, t;
    int base;
    req = '0;
    rst_n = 1'b0;
    #3;
    chk("rst_resp", resp, '0);
    chk("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata, mem_be}, '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    aw_send(64'h10, 8'd0, 2'b01, 4'd3);
    w_send(64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1, 1'b1, 10'd2);
    b_recv(4'd3, 2'b00, 0);
    ar_send(64'h10, 8'd0, 2'b01, 4'd4);
    r_recv(64'hDEADBEEF_CAFEF00D, 1'b1, 2'b00, 4'd4);

    aw_send(64'h0, 8'd3, 2'b01, 4'd1);
    for (int i = 0; i < 4; i++) w_send(64'(i + 1), 8'hFF, i == 3, 1'b1, 10'(i));
    b_recv(4'd1, 2'b00, 0);
    ar_send(64'h0, 8'd3, 2'b01, 4'd2);
    k = 0; t = 0;
    while (k < 4 && t < 60) begin
      @(negedge clk);
      if (resp.r_valid) begin
        chk("incr_data", resp.r.data, 64'(k + 1));
        chk("incr_last", resp.r.last, k == 3);
        if (req.r_ready) k++;
      end
      @(posedge clk); #1 req.r_ready = ~req.r_ready; t++;
    end
    req.r_ready = 1'b0;
    chk("incr_beats", k, 4);

    aw_send(64'h0, 8'd3, 2'b01, 4'd1);
    for (int i = 0; i < 4; i++) w_send(64'hA0 + 64'(i), 8'hFF, i == 3, 1'b1, 10'(i));
    b_recv(4'd1, 2'b00, 0);
    ar_send(64'h18, 8'd3, 2'b10, 4'd9);
    r_recv(64'hA3, 1'b0, 2'b00, 4'd9);
    r_recv(64'hA0, 1'b0, 2'b00, 4'd9);
    r_recv(64'hA1, 1'b0, 2'b00, 4'd9);
    r_recv(64'hA2, 1'b1, 2'b00, 4'd9);

    aw_send(64'h8, 8'd1, 2'b00, 4'd2);
    w_send(64'h11111111_11111111, 8'hFF, 1'b0, 1'b1, 10'd1);
    w_send(64'h22222222_22222222, 8'h0F, 1'b1, 1'b1, 10'd1);
    b_recv(4'd2, 2'b00, 0);
    ar_send(64'h8, 8'd0, 2'b01, 4'd2);
    r_recv(64'h11111111_22222222, 1'b1, 2'b00, 4'd2);

    req.aw.addr = 64'h40; req.aw.len = 8'd0; req.aw.size = 3'd3; req.aw.burst = 2'b01; req.aw.id = 4'd5;
    req.ar.addr = 64'h8;  req.ar.len = 8'd0; req.ar.size = 3'd3; req.ar.burst = 2'b01; req.ar.id = 4'd6;
    req.aw_valid = 1'b1; req.ar_valid = 1'b1;
    @(negedge clk);
    chk("arb1_aw_ready", resp.aw_ready, 1'b1);
    chk("arb1_ar_ready", resp.ar_ready, 1'b0);
    @(posedge clk); #1 req.aw_valid = 1'b0;
    w_send(64'h55555555_55555555, 8'hFF, 1'b1, 1'b1, 10'd8);
    b_recv(4'd5, 2'b00, 5);
    req.aw.id = 4'd7; req.aw_valid = 1'b1;
    @(negedge clk);
    chk("arb2_aw_ready", resp.aw_ready, 1'b0);
    chk("arb2_ar_ready", resp.ar_ready, 1'b1);
    @(posedge clk); #1 req.ar_valid = 1'b0;
    r_recv(64'h11111111_22222222, 1'b1, 2'b00, 4'd6);
    req.ar_valid = 1'b1;
    @(negedge clk);
    chk("arb3_aw_ready", resp.aw_ready, 1'b1);
    chk("arb3_ar_ready", resp.ar_ready, 1'b0);
    @(posedge clk); #1 req.aw_valid = 1'b0;
    w_send(64'h66666666_66666666, 8'hFF, 1'b1, 1'b1, 10'd8);
    b_recv(4'd7, 2'b00, 0);
    ar_send(64'h40, 8'd0, 2'b01, 4'd6);
    r_recv(64'h66666666_66666666, 1'b1, 2'b00, 4'd6);

`ifdef AXI_SOC_SRAM_BRIDGE_RANGE_ERR_EN
    base = n_memreq;
    ar_send(64'h2000, 8'd1, 2'b01, 4'd3);
    r_recv(64'h0, 1'b0, 2'b10, 4'd3);
    r_recv(64'h0, 1'b1, 2'b10, 4'd3);
    aw_send(64'h2000, 8'd0, 2'b01, 4'd4);
    w_send(64'hFFFF, 8'hFF, 1'b1, 1'b0, 10'd0);
    b_recv(4'd4, 2'b10, 0);
    @(negedge clk);
    chk("oor_no_mem_req", n_memreq - base, 0);
`else
    base = n_memreq;
    ar_send(64'h2000, 8'd0, 2'b01, 4'd3);
    r_recv(64'hA0, 1'b1, 2'b00, 4'd3);
    @(negedge clk);
    chk("alias_mem_req", n_memreq - base, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
